// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants.
// ALU encodings and the EX control bundle.
package pipeline_pkg;

  localparam int PKG_DATA_W = 32;
  localparam int PKG_REG_W  = 5;
  localparam int PKG_CTRL_W = 4;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_MUL = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLL = 4'd5;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_SRL = 4'd8;
  localparam logic [3:0] ALU_SLE = 4'd9;
  localparam logic [3:0] ALU_NOR = 4'd12;

  typedef struct packed {
    logic valid;
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic alu_src;
    logic shift_src;
  } ex_ctrl_t;

  localparam ex_ctrl_t EX_CTRL_BUBBLE = '0;

endpackage

// File: rtl/fwd_select.sv
// Priority forwarding mux for one source operand.
// EX/MEM beats MEM/WB; register 0 is never forwarded.
module fwd_select #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic [REG_W-1:0]  src_i,
  input  logic [DATA_W-1:0] rf_data_i,
  input  logic              mem_we_i,
  input  logic [REG_W-1:0]  mem_reg_i,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              wb_we_i,
  input  logic [REG_W-1:0]  wb_reg_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic [DATA_W-1:0] data_o
);

  logic nz;
  logic hit_mem;
  logic hit_wb;

  assign nz      = (src_i != '0);
  assign hit_mem = mem_we_i && (mem_reg_i == src_i) && nz;
  assign hit_wb  = wb_we_i && (wb_reg_i == src_i) && nz;

  // Newest producer wins; fall back to the register file.
  always_comb begin
    data_o = rf_data_i;
    if (hit_mem)
      data_o = mem_data_i;
    else if (hit_wb)
      data_o = wb_data_i;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with forwarding and
// load-use hazard detection feeding the ALU.
module id_ex_stage
  import pipeline_pkg::*;
#(
  parameter int DATA_W = PKG_DATA_W,
  parameter int REG_W  = PKG_REG_W,
  parameter int CTRL_W = PKG_CTRL_W,
  parameter int CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              ID_Valid,
  input  logic [DATA_W-1:0] ID_RsData,
  input  logic [DATA_W-1:0] ID_RtData,
  input  logic [DATA_W-1:0] ID_Imm,
  input  logic [4:0]        ID_Shamt,
  input  logic [REG_W-1:0]  ID_Rs,
  input  logic [REG_W-1:0]  ID_Rt,
  input  logic [REG_W-1:0]  ID_Rd,
  input  logic              ID_UsesRt,
  input  logic [CTRL_W-1:0] ID_ALUControl,
  input  logic              ID_ALUSrc,
  input  logic              ID_ShiftSrc,
  input  logic              ID_RegDst,
  input  logic              ID_RegWrite,
  input  logic              ID_MemRead,
  input  logic              ID_MemWrite,
  input  logic              Flush,
  input  logic              MEM_RegWrite,
  input  logic [REG_W-1:0]  MEM_WriteReg,
  input  logic [DATA_W-1:0] MEM_Result,
  input  logic              WB_RegWrite,
  input  logic [REG_W-1:0]  WB_WriteReg,
  input  logic [DATA_W-1:0] WB_Data,
  output logic              Stall,
  output logic              EX_Valid,
  output logic [CTRL_W-1:0] EX_ALUControl,
  output logic [DATA_W-1:0] EX_A,
  output logic [DATA_W-1:0] EX_B,
  output logic [DATA_W-1:0] EX_StoreData,
  output logic [REG_W-1:0]  EX_WriteReg,
  output logic              EX_RegWrite,
  output logic              EX_MemRead,
  output logic              EX_MemWrite,
  output logic [CNT_W-1:0]  StallCount
);

  ex_ctrl_t          ctrl_q, ctrl_d;
  logic [CTRL_W-1:0] alu_q, alu_d;
  logic [REG_W-1:0]  wreg_q, wreg_d;
  logic [REG_W-1:0]  rs_q, rs_d;
  logic [REG_W-1:0]  rt_q, rt_d;
  logic [DATA_W-1:0] rsd_q, rsd_d;
  logic [DATA_W-1:0] rtd_q, rtd_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [4:0]        sh_q, sh_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [DATA_W-1:0] fwd_rs;
  logic [DATA_W-1:0] fwd_rt;
  logic              hz_rs;
  logic              hz_rt;

  // Load in EX whose result a source of ID needs.
  assign hz_rs = (wreg_q == ID_Rs);
  assign hz_rt = ID_UsesRt && (wreg_q == ID_Rt);
  assign Stall = !Flush && ID_Valid && ctrl_q.valid
              && ctrl_q.mem_read && (wreg_q != '0)
              && (hz_rs || hz_rt);

  // Next state: bubble on flush/stall, else capture ID.
  always_comb begin
    ctrl_d = EX_CTRL_BUBBLE;
    alu_d  = alu_q;
    wreg_d = wreg_q;
    rs_d   = rs_q;
    rt_d   = rt_q;
    rsd_d  = rsd_q;
    rtd_d  = rtd_q;
    imm_d  = imm_q;
    sh_d   = sh_q;
    cnt_d  = cnt_q;
    if (!Flush && !Stall) begin
      ctrl_d.valid     = ID_Valid;
      ctrl_d.reg_write = ID_Valid && ID_RegWrite;
      ctrl_d.mem_read  = ID_Valid && ID_MemRead;
      ctrl_d.mem_write = ID_Valid && ID_MemWrite;
      ctrl_d.alu_src   = ID_ALUSrc;
      ctrl_d.shift_src = ID_ShiftSrc;
      alu_d  = ID_ALUControl;
      wreg_d = ID_RegDst ? ID_Rd : ID_Rt;
      rs_d   = ID_Rs;
      rt_d   = ID_Rt;
      rsd_d  = ID_RsData;
      rtd_d  = ID_RtData;
      imm_d  = ID_Imm;
      sh_d   = ID_Shamt;
    end
    if (Stall && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  // Pipeline register and stall counter.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ctrl_q <= EX_CTRL_BUBBLE;
      alu_q  <= '0;
      wreg_q <= '0;
      rs_q   <= '0;
      rt_q   <= '0;
      rsd_q  <= '0;
      rtd_q  <= '0;
      imm_q  <= '0;
      sh_q   <= '0;
      cnt_q  <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      alu_q  <= alu_d;
      wreg_q <= wreg_d;
      rs_q   <= rs_d;
      rt_q   <= rt_d;
      rsd_q  <= rsd_d;
      rtd_q  <= rtd_d;
      imm_q  <= imm_d;
      sh_q   <= sh_d;
      cnt_q  <= cnt_d;
    end
  end

  fwd_select #(.DATA_W(DATA_W), .REG_W(REG_W)) u_fwd_rs (
    .src_i      (rs_q),
    .rf_data_i  (rsd_q),
    .mem_we_i   (MEM_RegWrite),
    .mem_reg_i  (MEM_WriteReg),
    .mem_data_i (MEM_Result),
    .wb_we_i    (WB_RegWrite),
    .wb_reg_i   (WB_WriteReg),
    .wb_data_i  (WB_Data),
    .data_o     (fwd_rs)
  );

  fwd_select #(.DATA_W(DATA_W), .REG_W(REG_W)) u_fwd_rt (
    .src_i      (rt_q),
    .rf_data_i  (rtd_q),
    .mem_we_i   (MEM_RegWrite),
    .mem_reg_i  (MEM_WriteReg),
    .mem_data_i (MEM_Result),
    .wb_we_i    (WB_RegWrite),
    .wb_reg_i   (WB_WriteReg),
    .wb_data_i  (WB_Data),
    .data_o     (fwd_rt)
  );

  assign EX_A = ctrl_q.shift_src
              ? {{(DATA_W-5){1'b0}}, sh_q} : fwd_rs;
  assign EX_B = ctrl_q.alu_src ? imm_q : fwd_rt;
  assign EX_StoreData  = fwd_rt;
  assign EX_ALUControl = alu_q;
  assign EX_WriteReg   = wreg_q;
  assign EX_Valid      = ctrl_q.valid;
  assign EX_RegWrite   = ctrl_q.valid && ctrl_q.reg_write;
  assign EX_MemRead    = ctrl_q.valid && ctrl_q.mem_read;
  assign EX_MemWrite   = ctrl_q.valid && ctrl_q.mem_write;
  assign StallCount    = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage.
// Small stall counter so saturation is reachable.
module tb_id_ex_stage;

  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        ID_Valid, ID_UsesRt, ID_ALUSrc;
  logic        ID_ShiftSrc, ID_RegDst, ID_RegWrite;
  logic        ID_MemRead, ID_MemWrite, Flush;
  logic [31:0] ID_RsData, ID_RtData, ID_Imm;
  logic [4:0]  ID_Shamt, ID_Rs, ID_Rt, ID_Rd;
  logic [3:0]  ID_ALUControl;
  logic        MEM_RegWrite, WB_RegWrite;
  logic [4:0]  MEM_WriteReg, WB_WriteReg;
  logic [31:0] MEM_Result, WB_Data;
  logic        Stall, EX_Valid;
  logic [3:0]  EX_ALUControl;
  logic [31:0] EX_A, EX_B, EX_StoreData;
  logic [4:0]  EX_WriteReg;
  logic        EX_RegWrite, EX_MemRead, EX_MemWrite;
  logic [CW-1:0] StallCount;

  always #5 Clk = ~Clk;

  id_ex_stage #(.CNT_W(CW)) dut (
    .Clk(Clk), .Reset(Reset), .ID_Valid(ID_Valid),
    .ID_RsData(ID_RsData), .ID_RtData(ID_RtData),
    .ID_Imm(ID_Imm), .ID_Shamt(ID_Shamt),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd),
    .ID_UsesRt(ID_UsesRt), .ID_ALUControl(ID_ALUControl),
    .ID_ALUSrc(ID_ALUSrc), .ID_ShiftSrc(ID_ShiftSrc),
    .ID_RegDst(ID_RegDst), .ID_RegWrite(ID_RegWrite),
    .ID_MemRead(ID_MemRead), .ID_MemWrite(ID_MemWrite),
    .Flush(Flush), .MEM_RegWrite(MEM_RegWrite),
    .MEM_WriteReg(MEM_WriteReg), .MEM_Result(MEM_Result),
    .WB_RegWrite(WB_RegWrite), .WB_WriteReg(WB_WriteReg),
    .WB_Data(WB_Data), .Stall(Stall), .EX_Valid(EX_Valid),
    .EX_ALUControl(EX_ALUControl), .EX_A(EX_A), .EX_B(EX_B),
    .EX_StoreData(EX_StoreData), .EX_WriteReg(EX_WriteReg),
    .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead),
    .EX_MemWrite(EX_MemWrite), .StallCount(StallCount)
  );

  typedef struct {
    bit        valid, uses_rt, alusrc, shiftsrc, regdst;
    bit        regw, memr, memw, flush;
    bit [31:0] rsd, rtd, imm;
    bit [4:0]  shamt, rs, rt, rd;
    bit [3:0]  alu;
    bit        mem_we, wb_we;
    bit [4:0]  mem_reg, wb_reg;
    bit [31:0] mem_res, wb_data;
  } stim_t;

  typedef struct {
    bit        stall, valid, regw, memr, memw;
    bit [3:0]  alu;
    bit [4:0]  wreg;
    bit [31:0] a, b, sd;
    int        cnt;
  } exp_t;

  exp_t  q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  stim_t cur;
  stim_t slot;
  bit    slot_v = 0;
  int    model_cnt = 0;
  bit    exp_stall = 0;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  function automatic bit [31:0] fwd(bit [4:0] src,
                                    bit [31:0] rf, stim_t s);
    if (src == 0) return rf;
    if (s.mem_we && s.mem_reg == src) return s.mem_res;
    if (s.wb_we && s.wb_reg == src) return s.wb_data;
    return rf;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    s.valid    = $urandom_range(0, 4) != 0;
    s.uses_rt  = $urandom_range(0, 1) != 0;
    s.alusrc   = $urandom_range(0, 1) != 0;
    s.shiftsrc = $urandom_range(0, 3) == 0;
    s.regdst   = $urandom_range(0, 1) != 0;
    s.regw     = $urandom_range(0, 1) != 0;
    s.memr     = $urandom_range(0, 2) == 0;
    s.memw     = $urandom_range(0, 3) == 0;
    s.flush    = $urandom_range(0, 7) == 0;
    s.rsd      = $urandom;
    s.rtd      = $urandom;
    s.imm      = $urandom;
    s.shamt    = 5'($urandom);
    s.rs       = 5'($urandom_range(0, 3));
    s.rt       = 5'($urandom_range(0, 3));
    s.rd       = 5'($urandom_range(0, 3));
    s.alu      = 4'($urandom);
    s.mem_we   = $urandom_range(0, 1) != 0;
    s.wb_we    = $urandom_range(0, 1) != 0;
    s.mem_reg  = 5'($urandom_range(0, 3));
    s.wb_reg   = 5'($urandom_range(0, 3));
    s.mem_res  = $urandom;
    s.wb_data  = $urandom;
    return s;
  endfunction

  // Drive one cycle of inputs and queue what EX must show.
  task automatic apply(stim_t s);
    exp_t e;
    bit [4:0] wr;
    cur = s;
    ID_Valid = s.valid; ID_UsesRt = s.uses_rt;
    ID_ALUSrc = s.alusrc; ID_ShiftSrc = s.shiftsrc;
    ID_RegDst = s.regdst; ID_RegWrite = s.regw;
    ID_MemRead = s.memr; ID_MemWrite = s.memw;
    Flush = s.flush; ID_RsData = s.rsd;
    ID_RtData = s.rtd; ID_Imm = s.imm;
    ID_Shamt = s.shamt; ID_Rs = s.rs; ID_Rt = s.rt;
    ID_Rd = s.rd; ID_ALUControl = s.alu;
    MEM_RegWrite = s.mem_we; MEM_WriteReg = s.mem_reg;
    MEM_Result = s.mem_res; WB_RegWrite = s.wb_we;
    WB_WriteReg = s.wb_reg; WB_Data = s.wb_data;
    wr = slot.regdst ? slot.rd : slot.rt;
    exp_stall = !s.flush && s.valid && slot_v && slot.memr
             && wr != 0
             && (wr == s.rs || (s.uses_rt && wr == s.rt));
    e.stall = exp_stall;
    e.valid = slot_v;
    e.regw  = slot_v && slot.regw;
    e.memr  = slot_v && slot.memr;
    e.memw  = slot_v && slot.memw;
    e.alu   = slot.alu;
    e.wreg  = wr;
    e.a     = slot.shiftsrc ? {27'b0, slot.shamt}
                            : fwd(slot.rs, slot.rsd, s);
    e.b     = slot.alusrc ? slot.imm
                          : fwd(slot.rt, slot.rtd, s);
    e.sd    = fwd(slot.rt, slot.rtd, s);
    e.cnt   = model_cnt;
    q.push_back(e);
  endtask

  // Advance the reference model across one clock edge.
  task automatic tick();
    @(posedge Clk);
    if (exp_stall && model_cnt < CMAX) model_cnt++;
    if (cur.flush || exp_stall) slot_v = 0;
    else begin
      slot = cur;
      slot_v = cur.valid;
    end
    #1;
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_valid"}, 32'(EX_Valid), 0);
    chk({tag, "_a"}, EX_A, 0);
    chk({tag, "_b"}, EX_B, 0);
    chk({tag, "_sd"}, EX_StoreData, 0);
    chk({tag, "_wreg"}, 32'(EX_WriteReg), 0);
    chk({tag, "_alu"}, 32'(EX_ALUControl), 0);
    chk({tag, "_ctl"},
        32'({EX_RegWrite, EX_MemRead, EX_MemWrite}), 0);
    chk({tag, "_cnt"}, 32'(StallCount), 0);
    chk({tag, "_stall"}, 32'(Stall), 0);
  endtask

  task automatic model_reset();
    q.delete();
    slot = idle();
    slot_v = 0;
    model_cnt = 0;
    exp_stall = 0;
  endtask

  // Monitor: compare the queued expectation each cycle.
  always @(negedge Clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("stall", 32'(Stall), 32'(e.stall));
      chk("ex_valid", 32'(EX_Valid), 32'(e.valid));
      chk("regwrite", 32'(EX_RegWrite), 32'(e.regw));
      chk("memread", 32'(EX_MemRead), 32'(e.memr));
      chk("memwrite", 32'(EX_MemWrite), 32'(e.memw));
      chk("stallcount", 32'(StallCount), 32'(e.cnt));
      if (e.valid) begin
        chk("alu", 32'(EX_ALUControl), 32'(e.alu));
        chk("wreg", 32'(EX_WriteReg), 32'(e.wreg));
        chk("ex_a", EX_A, e.a);
        chk("ex_b", EX_B, e.b);
        chk("store", EX_StoreData, e.sd);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    stim_t s, lw, add;
    model_reset();
    apply(idle());
    q.delete();
    #1;
    chk_all_zero("reset0");
    @(posedge Clk); #1;
    Reset = 1'b1;
    apply(idle()); tick();

    // ADD with forwarding from both stages.
    add = idle();
    add.valid = 1; add.rs = 8; add.rsd = 32'h5;
    add.rt = 9; add.rtd = 32'h3; add.uses_rt = 1;
    add.rd = 11; add.regdst = 1; add.regw = 1;
    add.alu = 4'd2;
    apply(add); tick();
    s = idle();
    s.mem_we = 1; s.mem_reg = 8; s.mem_res = 32'h10;
    s.wb_we = 1; s.wb_reg = 8; s.wb_data = 32'h20;
    apply(s); #2;
    chk("fwd_mem_a", EX_A, 32'h10);
    chk("fwd_mem_b", EX_B, 32'h3);
    tick();
    apply(add); tick();
    s.mem_we = 0;
    apply(s); #2;
    chk("fwd_wb_a", EX_A, 32'h20);
    tick();

    // Register 0 is never forwarded.
    s = idle();
    s.valid = 1; s.rs = 0; s.rsd = 0; s.regw = 1;
    apply(s); tick();
    s = idle();
    s.mem_we = 1; s.mem_reg = 0; s.mem_res = 32'hFFFF;
    apply(s); #2;
    chk("reg0_a", EX_A, 32'h0);
    tick();

    // Load-use: LW r10 then ADD reading r10.
    lw = idle();
    lw.valid = 1; lw.rt = 10; lw.regdst = 0;
    lw.memr = 1; lw.regw = 1; lw.alusrc = 1;
    lw.imm = 32'h40; lw.alu = 4'd2;
    add = idle();
    add.valid = 1; add.rs = 10; add.rt = 3;
    add.rd = 4; add.regdst = 1; add.regw = 1;
    add.alu = 4'd2; add.uses_rt = 1;
    apply(lw); tick();
    apply(add); #2;
    chk("lu_stall", 32'(Stall), 1);
    tick();
    s = add;
    s.mem_we = 1; s.mem_reg = 10; s.mem_res = 32'hABC;
    apply(s); #2;
    chk("lu_stall_off", 32'(Stall), 0);
    chk("lu_bubble", 32'(EX_Valid), 0);
    chk("lu_bubble_rw", 32'(EX_RegWrite), 0);
    chk("lu_count", 32'(StallCount), 1);
    tick();
    s = idle();
    s.mem_we = 1; s.mem_reg = 10; s.mem_res = 32'hABC;
    apply(s); #2;
    chk("lu_add_valid", 32'(EX_Valid), 1);
    chk("lu_add_a", EX_A, 32'hABC);
    tick();

    // Hazard with a simultaneous flush.
    lw.rt = 12;
    apply(lw); tick();
    s = add;
    s.rs = 12; s.flush = 1;
    apply(s); #2;
    chk("flush_stall", 32'(Stall), 0);
    tick();
    apply(idle()); #2;
    chk("flush_bubble", 32'(EX_Valid), 0);
    chk("flush_count", 32'(StallCount), 1);
    tick();

    // SLL uses shamt on A and Rt on B.
    s = idle();
    s.valid = 1; s.alu = 4'd5; s.shiftsrc = 1;
    s.shamt = 4; s.rt = 5; s.rtd = 32'h1;
    s.rd = 6; s.regdst = 1; s.regw = 1;
    apply(s); tick();
    apply(idle()); #2;
    chk("sll_a", EX_A, 32'h4);
    chk("sll_b", EX_B, 32'h1);
    chk("sll_alu", 32'(EX_ALUControl), 32'h5);
    tick();

    // Drive the counter into saturation.
    lw.rt = 7;
    add.rs = 7;
    for (int i = 0; i < CMAX + 5; i++) begin
      apply(lw); tick();
      apply(add); tick();
      apply(add); tick();
    end
    apply(idle()); #2;
    chk("sat_count", 32'(StallCount), 32'(CMAX));
    tick();

    for (int i = 0; i < 2000; i++) begin
      apply(rnd()); tick();
    end

    // Asynchronous reset while EX holds an instruction.
    s = idle();
    s.valid = 1; s.rs = 2; s.rsd = 32'h77;
    s.regw = 1; s.alu = 4'd1;
    apply(s); tick();
    chk("pre_reset_valid", 32'(EX_Valid), 1);
    Reset = 1'b0;
    model_reset();
    #1;
    chk_all_zero("reset1");
    @(posedge Clk); #1;
    Reset = 1'b1;
    apply(idle()); tick();
    chk("post_reset_valid", 32'(EX_Valid), 0);
    apply(idle()); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
